uart_rx_fifo: RTL

//   Receive buffer directly downstream of the UART receiver. Captures every one-cycle
//   rx_valid pulse (data + BREAK flag) into a DEPTH-entry circular FIFO. Presents entries
//   to the host side with a first-word-fall-through valid/ready interface.

---
 rtl/uart_rx_fifo.sv | 117 +++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: DEPTH-entry circular FIFO with a first-word-fall-through output.
// Latency: one cycle from an rx_valid pulse to out_valid on an empty FIFO. out_data/out_break are combinational from the head entry.
// Backpressure: out_ready stalls the head. A character that arrives while the FIFO is full and nothing is read is dropped and sets sticky overflow.
module uart_rx_fifo #(
  parameter int PAYLOAD_BITS = 8,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = 12,
  parameter bit DROP_BREAK   = 1'b0,
  parameter int ADDR_W       = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_valid,
  input  logic                    rx_break,
  input  logic [PAYLOAD_BITS-1:0] rx_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PAYLOAD_BITS-1:0] out_data,
  output logic                    out_break,
  output logic [ADDR_W:0]         count,
  output logic                    full,
  output logic                    almost_full,
  output logic                    overflow,
  input  logic                    ovf_clear,
  output logic                    brk_seen
);

  localparam int        THRESH_I = AFULL_THRESH;
  localparam int        DEPTH_I  = DEPTH;
  localparam logic [ADDR_W:0] DEPTH_C = DEPTH_I[ADDR_W:0];
  localparam logic [ADDR_W:0] AFULL_C = THRESH_I[ADDR_W:0];

  // Each entry holds the BREAK flag above the character bits.
  logic [PAYLOAD_BITS:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              brk_q, brk_d;

  logic empty;
  logic keep;
  logic wr_en;
  logic rd_en;
  logic ovf_set;

  // Status flags come from the count register alone, never from the rx_* inputs.
  always_comb begin
    empty       = (count_q == '0);
    full        = (count_q == DEPTH_C);
    almost_full = (count_q >= AFULL_C);
    count       = count_q;
    overflow    = ovf_q;
    brk_seen    = brk_q;
  end

  // Accept/drop decisions. A filtered BREAK is neither stored nor counted as an overflow.
  always_comb begin
    keep    = rx_valid && !(DROP_BREAK && rx_break);
    rd_en   = !empty && out_ready;
    wr_en   = keep && (!full || rd_en);
    ovf_set = keep && full && !rd_en;
  end

  // Head of the FIFO. The output is forced to zero while empty, so stale memory never leaks out.
  always_comb begin
    out_valid = !empty;
    out_data  = '0;
    out_break = 1'b0;
    if (!empty) begin
      out_data  = mem_q[rd_ptr_q][PAYLOAD_BITS-1:0];
      out_break = mem_q[rd_ptr_q][PAYLOAD_BITS];
    end
  end

  // Next-state logic. Pointers wrap naturally because DEPTH is a power of two. Overflow set wins over clear.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    brk_d    = rx_valid && rx_break;
    if (wr_en) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
    if (ovf_set)        ovf_d = 1'b1;
    else if (ovf_clear) ovf_d = 1'b0;
  end

  // Control registers with a synchronous, active-low reset that discards all entries.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      brk_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      brk_q    <= brk_d;
    end
  end

  // Storage array. It is not reset; a write happens only on an accepted character.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {rx_break, rx_data};
  end

endmodule
